// File: rtl/alu_pkg.sv
// alu_pkg: shared types for pipelined_alu.
// Optional multiplier is selected with the ALU_MUL_EN macro (see pipelined_alu).
package alu_pkg;

    localparam int unsigned OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_SHL = 4'd2,
        OP_SHR = 4'd3,
        OP_AND = 4'd4,
        OP_OR  = 4'd5,
        OP_XOR = 4'd6,
        OP_EQ  = 4'd7,
        OP_SLT = 4'd8,
        OP_SRA = 4'd9,
        OP_MUL = 4'd10
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

    typedef struct packed {
        logic zero;
        logic carry;
        logic ovf;
        logic err;
    } flags_t;

    // Opcodes above MUL are never legal; MUL is legal only when the multiplier is built.
    function automatic logic op_illegal(input logic [OP_W-1:0] op, input logic mul_en);
        return (op > 4'd10) || ((op == 4'd10) && !mul_en);
    endfunction

endpackage

// File: rtl/pipelined_alu_if.sv
// pipelined_alu_if: operand-issue and result-writeback handshake bundle.
// slave is the ALU view, master is the issue/writeback side.
interface pipelined_alu_if #(
    parameter int unsigned WIDTH = 8
);
    import alu_pkg::*;

    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [OP_W-1:0]  op_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] alu_o;
    logic             zero_o;
    logic             carry_o;
    logic             ovf_o;
    logic             err_o;

    modport slave (
        input  in_valid_i, a_i, b_i, op_i, out_ready_i,
        output in_ready_o, out_valid_o, alu_o, zero_o, carry_o, ovf_o, err_o
    );

    modport master (
        output in_valid_i, a_i, b_i, op_i, out_ready_i,
        input  in_ready_o, out_valid_o, alu_o, zero_o, carry_o, ovf_o, err_o
    );

endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add multiplier, one bit of b per cycle.
// done_o/product_o are combinational on the final step so the caller can
// register the product on the WIDTH-th edge after start_i.
module alu_mul_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);

    localparam int unsigned        CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(WIDTH - 1);

    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_step;

    assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done_o    = busy_q && (cnt_q == LAST);
    assign product_o = acc_step;

    // Load operands on start, then accumulate one partial product per cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (start_i) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= a_i;
            mplier_q <= b_i;
        end else if (busy_q) begin
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipelined_alu.sv
// pipelined_alu: registered ALU with valid/ready on both sides and status flags.
// Define ALU_MUL_EN to build the iterative multiplier for opcode 10;
// otherwise opcode 10 is reported as illegal and the FSM stays in IDLE.
module pipelined_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    pipelined_alu_if.slave bus
);

    localparam int unsigned SH_W = $clog2(WIDTH);
`ifdef ALU_MUL_EN
    localparam logic MUL_EN = 1'b1;
`else
    localparam logic MUL_EN = 1'b0;
`endif

    state_e           state_q, state_d;
    logic             accept;
    logic             load;
    logic             illegal;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             big_shift;
    logic [SH_W-1:0]  sh_amt;
    logic [WIDTH-1:0] res_sc, res_d;
    flags_t           flg_sc, flg_d;
    logic             out_valid_q;
    logic [WIDTH-1:0] alu_q;
    flags_t           flg_q;

`ifdef ALU_MUL_EN
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    alu_mul_seq #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start_i  (mul_start),
        .a_i      (bus.a_i),
        .b_i      (bus.b_i),
        .done_o   (mul_done),
        .product_o(mul_product)
    );
`endif

    assign bus.in_ready_o  = (state_q == IDLE) && (!out_valid_q || bus.out_ready_i);
    assign accept          = bus.in_valid_i && bus.in_ready_o;
    assign illegal         = op_illegal(bus.op_i, MUL_EN);

    assign bus.out_valid_o = out_valid_q;
    assign bus.alu_o       = alu_q;
    assign bus.zero_o      = flg_q.zero;
    assign bus.carry_o     = flg_q.carry;
    assign bus.ovf_o       = flg_q.ovf;
    assign bus.err_o       = flg_q.err;

    // Single-cycle datapath and its flags.
    always_comb begin
        sum       = {1'b0, bus.a_i} + {1'b0, bus.b_i};
        diff      = {1'b0, bus.a_i} - {1'b0, bus.b_i};
        big_shift = (bus.b_i >= WIDTH'(WIDTH));
        sh_amt    = bus.b_i[SH_W-1:0];
        res_sc    = '0;
        flg_sc    = '0;
        if (illegal) begin
            flg_sc.err = 1'b1;
        end else begin
            case (bus.op_i)
                OP_ADD: begin
                    res_sc       = sum[WIDTH-1:0];
                    flg_sc.carry = sum[WIDTH];
                    flg_sc.ovf   = (bus.a_i[WIDTH-1] == bus.b_i[WIDTH-1]) &&
                                   (sum[WIDTH-1] != bus.a_i[WIDTH-1]);
                end
                OP_SUB: begin
                    res_sc       = diff[WIDTH-1:0];
                    flg_sc.carry = diff[WIDTH];
                    flg_sc.ovf   = (bus.a_i[WIDTH-1] != bus.b_i[WIDTH-1]) &&
                                   (diff[WIDTH-1] != bus.a_i[WIDTH-1]);
                end
                OP_SHL:  res_sc = big_shift ? '0 : (bus.a_i << sh_amt);
                OP_SHR:  res_sc = big_shift ? '0 : (bus.a_i >> sh_amt);
                OP_AND:  res_sc = bus.a_i & bus.b_i;
                OP_OR:   res_sc = bus.a_i | bus.b_i;
                OP_XOR:  res_sc = bus.a_i ^ bus.b_i;
                OP_EQ:   res_sc = {{(WIDTH-1){1'b0}}, (bus.a_i == bus.b_i)};
                OP_SLT:  res_sc = {{(WIDTH-1){1'b0}}, ($signed(bus.a_i) < $signed(bus.b_i))};
                OP_SRA:  res_sc = big_shift ? {WIDTH{bus.a_i[WIDTH-1]}}
                                            : WIDTH'($signed(bus.a_i) >>> sh_amt);
                default: res_sc = '0;
            endcase
        end
        flg_sc.zero = (res_sc == '0);
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, multiplier start and output-register load selection.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        res_d   = res_sc;
        flg_d   = flg_sc;
`ifdef ALU_MUL_EN
        mul_start = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef ALU_MUL_EN
                    if (bus.op_i == OP_MUL) begin
                        state_d   = MUL;
                        mul_start = 1'b1;
                    end else begin
                        load = 1'b1;
                    end
`else
                    load = 1'b1;
`endif
                end
            end
`ifdef ALU_MUL_EN
            MUL: begin
                if (mul_done) begin
                    load       = 1'b1;
                    res_d      = mul_product;
                    flg_d      = '0;
                    flg_d.zero = (mul_product == '0);
                    state_d    = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Output register: load replaces a consumed result, otherwise hold until taken.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            alu_q       <= '0;
            flg_q       <= '0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            alu_q       <= res_d;
            flg_q       <= flg_d;
        end else if (bus.out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipelined_alu.sv
// tb_pipelined_alu: directed table-driven bench for pipelined_alu (WIDTH=8),
// plus hand sequences for backpressure, async reset and (with ALU_MUL_EN) MUL.
module tb_pipelined_alu;
    import alu_pkg::*;

    localparam int unsigned WIDTH = 8;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       z;
        logic       c;
        logic       o;
        logic       e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipelined_alu_if #(.WIDTH(WIDTH)) bus();

    pipelined_alu #(.WIDTH(WIDTH)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    vec_t vecs[32];
    int   n_vec    = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] res, input logic z, input logic c,
                       input logic o, input logic e);
        vecs[n_vec] = '{op: op, a: a, b: b, res: res, z: z, c: c, o: o, e: e};
        n_vec++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.in_valid_i = 1'b1;
        bus.op_i       = op;
        bus.a_i        = a;
        bus.b_i        = b;
    endtask

    task automatic check_out(input string tag, input vec_t v);
        check({tag, "_valid"}, 64'(bus.out_valid_o), 64'(1'b1));
        check({tag, "_alu"},   64'(bus.alu_o),       64'(v.res));
        check({tag, "_zero"},  64'(bus.zero_o),      64'(v.z));
        check({tag, "_carry"}, 64'(bus.carry_o),     64'(v.c));
        check({tag, "_ovf"},   64'(bus.ovf_o),       64'(v.o));
        check({tag, "_err"},   64'(bus.err_o),       64'(v.e));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          op     a      b      res    z  c  o  e
        add(4'd0,  8'h05, 8'h03, 8'h08, 0, 0, 0, 0);   // ADD
        add(4'd1,  8'h05, 8'h03, 8'h02, 0, 0, 0, 0);   // SUB
        add(4'd2,  8'h05, 8'h02, 8'h14, 0, 0, 0, 0);   // SHL
        add(4'd3,  8'h08, 8'h02, 8'h02, 0, 0, 0, 0);   // SHR
        add(4'd4,  8'hF0, 8'h0F, 8'h00, 1, 0, 0, 0);   // AND
        add(4'd5,  8'hF0, 8'h0F, 8'hFF, 0, 0, 0, 0);   // OR
        add(4'd6,  8'hF0, 8'h0F, 8'hFF, 0, 0, 0, 0);   // XOR
        add(4'd7,  8'h07, 8'h07, 8'h01, 0, 0, 0, 0);   // EQ equal
        add(4'd7,  8'h07, 8'h09, 8'h00, 1, 0, 0, 0);   // EQ differ
        add(4'd8,  8'h80, 8'h01, 8'h01, 0, 0, 0, 0);   // SLT -128 < 1
        add(4'd8,  8'h01, 8'h80, 8'h00, 1, 0, 0, 0);   // SLT 1 < -128 false
        add(4'd9,  8'h80, 8'h03, 8'hF0, 0, 0, 0, 0);   // SRA
        add(4'd0,  8'hFF, 8'h01, 8'h00, 1, 1, 0, 0);   // ADD carry out
        add(4'd0,  8'h7F, 8'h01, 8'h80, 0, 0, 1, 0);   // ADD signed overflow
        add(4'd1,  8'h03, 8'h05, 8'hFE, 0, 1, 0, 0);   // SUB borrow
        add(4'd1,  8'h80, 8'h01, 8'h7F, 0, 0, 1, 0);   // SUB signed overflow
        add(4'd2,  8'h01, 8'h07, 8'h80, 0, 0, 0, 0);   // SHL max in-range
        add(4'd2,  8'h01, 8'h08, 8'h00, 1, 0, 0, 0);   // SHL amount == WIDTH
        add(4'd3,  8'h80, 8'h08, 8'h00, 1, 0, 0, 0);   // SHR amount == WIDTH
        add(4'd9,  8'h80, 8'hC8, 8'hFF, 0, 0, 0, 0);   // SRA amount 200
        add(4'd9,  8'h40, 8'h07, 8'h00, 1, 0, 0, 0);   // SRA positive
        add(4'd15, 8'h12, 8'h34, 8'h00, 1, 0, 0, 1);   // illegal 15
        add(4'd11, 8'hFF, 8'hFF, 8'h00, 1, 0, 0, 1);   // illegal 11
`ifndef ALU_MUL_EN
        add(4'd10, 8'h0D, 8'h0B, 8'h00, 1, 0, 0, 1);   // MUL without multiplier
`endif

        // Reset state
        rst_n           = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.op_i        = '0;
        bus.a_i         = '0;
        bus.b_i         = '0;
        bus.out_ready_i = 1'b1;
        #12;
        check("rst_valid", 64'(bus.out_valid_o), 64'(1'b0));
        check("rst_alu",   64'(bus.alu_o),       64'(8'h00));
        check("rst_flags", 64'({bus.zero_o, bus.carry_o, bus.ovf_o, bus.err_o}), 64'(4'b0000));
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(bus.in_ready_o), 64'(1'b1));

        // Back-to-back vectors: one result per cycle under continuous out_ready_i
        for (int i = 0; i < n_vec; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b);
            #1;
            check($sformatf("vec%0d_in_ready", i), 64'(bus.in_ready_o), 64'(1'b1));
            tick();
            check_out($sformatf("vec%0d", i), vecs[i]);
        end
        bus.in_valid_i = 1'b0;
        tick();
        check("drain_valid", 64'(bus.out_valid_o), 64'(1'b0));

        // Backpressure: result held stable, no new op accepted
        bus.out_ready_i = 1'b0;
        drive(4'd0, 8'h7F, 8'h01);
        tick();
        drive(4'd6, 8'h0F, 8'h0F);
        for (int k = 0; k < 3; k++) begin
            check_out($sformatf("bp%0d", k), '{op: 4'd0, a: 8'h7F, b: 8'h01, res: 8'h80,
                                              z: 1'b0, c: 1'b0, o: 1'b1, e: 1'b0});
            check($sformatf("bp%0d_in_ready", k), 64'(bus.in_ready_o), 64'(1'b0));
            tick();
        end
        bus.out_ready_i = 1'b1;
        #1;
        check("bp_release_in_ready", 64'(bus.in_ready_o), 64'(1'b1));
        tick();
        check_out("bp_next", '{op: 4'd6, a: 8'h0F, b: 8'h0F, res: 8'h00,
                               z: 1'b1, c: 1'b0, o: 1'b0, e: 1'b0});
        bus.in_valid_i = 1'b0;
        tick();
        check("bp_drain_valid", 64'(bus.out_valid_o), 64'(1'b0));

        // Asynchronous reset clears a pending result immediately
        bus.out_ready_i = 1'b0;
        drive(4'd5, 8'hF0, 8'h0F);
        tick();
        bus.in_valid_i = 1'b0;
        check("ar_pending_alu", 64'(bus.alu_o), 64'(8'hFF));
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 64'(bus.out_valid_o), 64'(1'b0));
        check("ar_alu",   64'(bus.alu_o),       64'(8'h00));
        tick();
        rst_n           = 1'b1;
        bus.out_ready_i = 1'b1;
        tick();

`ifdef ALU_MUL_EN
        // MUL 0D*0B = 0x8F after WIDTH cycles, input blocked throughout
        drive(4'd10, 8'h0D, 8'h0B);
        tick();
        bus.in_valid_i = 1'b0;
        check("mul_busy0_in_ready", 64'(bus.in_ready_o), 64'(1'b0));
        check("mul_busy0_valid",    64'(bus.out_valid_o), 64'(1'b0));
        for (int k = 1; k < WIDTH; k++) begin
            tick();
            check($sformatf("mul_busy%0d_in_ready", k), 64'(bus.in_ready_o), 64'(1'b0));
            check($sformatf("mul_busy%0d_valid", k),    64'(bus.out_valid_o), 64'(1'b0));
        end
        tick();
        check_out("mul", '{op: 4'd10, a: 8'h0D, b: 8'h0B, res: 8'h8F,
                           z: 1'b0, c: 1'b0, o: 1'b0, e: 1'b0});
        tick();
        check("mul_drain_valid", 64'(bus.out_valid_o), 64'(1'b0));
        check("mul_drain_in_ready", 64'(bus.in_ready_o), 64'(1'b1));

        // Reset mid-MUL discards the operation
        drive(4'd10, 8'h0D, 8'h0B);
        tick();
        bus.in_valid_i = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("mulrst_valid", 64'(bus.out_valid_o), 64'(1'b0));
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < WIDTH + 4; k++) begin
            tick();
            check($sformatf("mulrst_stale%0d", k), 64'(bus.out_valid_o), 64'(1'b0));
        end
        check("mulrst_in_ready", 64'(bus.in_ready_o), 64'(1'b1));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
